dma: RTL and testbench

//  Word-serial DMA between external memory and on-chip buffers of the conv accelerator.
//  On command it fetches layer info (latched on inf_conv), an fmi tile, or a kernel block,
//  one 32-bit word per request, and streams fetched data words to on-chip RAM via write/ram_addr/ram_data.

---
 rtl/dma.sv | 167 ++++++++++++++++
 tb/tb_dma.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/dma.sv
// Word-serial DMA: fetches layer info, kernel blocks or an fmi tile from external
// memory one word per request and streams the words into on-chip RAM.
module dma #(
  parameter logic [31:0] OFFSET_INF_CONV = 32'h0000_0000,
  parameter logic [31:0] OFFSET_FMI      = 32'h0000_0100,
  parameter logic [31:0] OFFSET_KEX      = 32'h0010_0000,
  parameter logic [31:0] OFFSET_KPW      = 32'h0018_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_op,
  input  logic [2:0]  op,
  input  logic [7:0]  tx_i,
  input  logic [7:0]  ty_i,
  input  logic [7:0]  x_mem_i,
  input  logic [7:0]  y_mem_i,
  output logic        r_request_extmem,
  output logic [31:0] addr_extmem,
  input  logic        r_valid_extmem,
  input  logic [31:0] data_extmem,
  output logic        write,
  output logic [15:0] ram_addr,
  output logic [31:0] ram_data,
  output logic [41:0] inf_conv,
  output logic        e_op
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, WR, DONE} state_t;
  state_t state;

  logic [2:0]  op_r;
  logic [7:0]  tx_r, ty_r, xm_r, ym_r;
  logic [31:0] k, total;
  logic [7:0]  xo, yo;
  logic [10:0] c;

  logic [7:0]  xo_n, yo_n;
  logic [10:0] c_n;
  logic [31:0] k_n, cnt0, addr0, addr_n;
  logic [7:0]  w_f, h_f;
  logic [10:0] c_f, e_f;

  assign w_f = inf_conv[7:0];
  assign h_f = inf_conv[15:8];
  assign c_f = inf_conv[26:16];
  assign e_f = inf_conv[37:27];

  function automatic logic [31:0] word_addr(input logic [2:0] o, input logic [10:0] cc,
                                            input logic [31:0] y, input logic [31:0] x,
                                            input logic [31:0] kk, input logic [7:0] w,
                                            input logic [7:0] h);
    case (o)
      3'd0:    return OFFSET_INF_CONV + kk;
      3'd1:    return OFFSET_KEX + kk;
      3'd2:    return OFFSET_KPW + kk;
      default: return OFFSET_FMI + (32'(cc) * 32'(h) + y) * 32'(w) + x;
    endcase
  endfunction

  // Tile walk: x fastest, then y, then channel.
  always_comb begin
    xo_n = xo + 8'd1;
    yo_n = yo;
    c_n  = c;
    k_n  = k + 32'd1;
    if (xo == xm_r) begin
      xo_n = 8'd0;
      if (yo == ym_r) begin
        yo_n = 8'd0;
        c_n  = c + 11'd1;
      end else begin
        yo_n = yo + 8'd1;
      end
    end
    case (op)
      3'd0:      cnt0 = 32'd2;
      3'd1, 3'd2: cnt0 = 32'(c_f) * 32'(e_f);
      3'd3:      cnt0 = 32'(c_f) * (32'(y_mem_i) + 32'd1) * (32'(x_mem_i) + 32'd1);
      default:   cnt0 = 32'd0;
    endcase
    addr0  = word_addr(op, 11'd0, 32'(ty_i), 32'(tx_i), 32'd0, w_f, h_f);
    addr_n = word_addr(op_r, c_n, 32'(ty_r) + 32'(yo_n), 32'(tx_r) + 32'(xo_n), k_n, w_f, h_f);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      op_r             <= '0;
      tx_r             <= '0;
      ty_r             <= '0;
      xm_r             <= '0;
      ym_r             <= '0;
      k                <= '0;
      total            <= '0;
      xo               <= '0;
      yo               <= '0;
      c                <= '0;
      r_request_extmem <= 1'b0;
      addr_extmem      <= '0;
      write            <= 1'b0;
      ram_addr         <= '0;
      ram_data         <= '0;
      inf_conv         <= '0;
      e_op             <= 1'b0;
    end else begin
      case (state)
        IDLE: if (s_op) begin
          op_r     <= op;
          tx_r     <= tx_i;
          ty_r     <= ty_i;
          xm_r     <= x_mem_i;
          ym_r     <= y_mem_i;
          k        <= '0;
          xo       <= '0;
          yo       <= '0;
          c        <= '0;
          ram_addr <= '0;
          total    <= cnt0;
          if (op[2] || cnt0 == 32'd0) begin
            e_op  <= 1'b1;
            state <= DONE;
          end else begin
            r_request_extmem <= 1'b1;
            addr_extmem      <= addr0;
            state            <= REQ;
          end
        end
        REQ: begin
          r_request_extmem <= 1'b0;
          state            <= WAIT;
        end
        WAIT: if (r_valid_extmem) begin
          ram_data <= data_extmem;
          ram_addr <= k[15:0];
          if (op_r == 3'd0) begin
            if (k == 32'd0) inf_conv[31:0]  <= data_extmem;
            else            inf_conv[41:32] <= data_extmem[9:0];
          end else begin
            write <= 1'b1;
          end
          state <= WR;
        end
        WR: begin
          write <= 1'b0;
          if (k == total - 32'd1) begin
            e_op  <= 1'b1;
            state <= DONE;
          end else begin
            k                <= k_n;
            xo               <= xo_n;
            yo               <= yo_n;
            c                <= c_n;
            r_request_extmem <= 1'b1;
            addr_extmem      <= addr_n;
            state            <= REQ;
          end
        end
        DONE: begin
          e_op  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma.sv
// Scoreboard bench for dma: a behavioural external memory answers requests after a
// programmable delay; expected addresses and RAM writes are queued at command time.
module tb_dma;
  logic        clk = 0, rst = 0, s_op = 0;
  logic [2:0]  op = 0;
  logic [7:0]  tx_i = 0, ty_i = 0, x_mem_i = 0, y_mem_i = 0;
  logic        r_request_extmem, write, e_op;
  logic [31:0] addr_extmem, ram_data;
  logic        r_valid_extmem = 0;
  logic [31:0] data_extmem = 0;
  logic [15:0] ram_addr;
  logic [41:0] inf_conv;

  dma dut (
    .clk(clk), .rst(rst), .s_op(s_op), .op(op), .tx_i(tx_i), .ty_i(ty_i),
    .x_mem_i(x_mem_i), .y_mem_i(y_mem_i), .r_request_extmem(r_request_extmem),
    .addr_extmem(addr_extmem), .r_valid_extmem(r_valid_extmem), .data_extmem(data_extmem),
    .write(write), .ram_addr(ram_addr), .ram_data(ram_data), .inf_conv(inf_conv), .e_op(e_op)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0, eop_cnt = 0, delay = 1;
  logic [31:0] info0 = 0, info1 = 0;
  logic [41:0] model_info = 0;
  logic [31:0] aq[$];
  logic [47:0] wq[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'd0) return info0;
    if (a == 32'd1) return info1;
    return a * 32'h9E37_79B9 + 32'h0123_4567;
  endfunction

  // External memory model plus output monitor, both on the falling edge.
  logic        pend = 0;
  int          cnt = 0;
  logic [31:0] paddr = 0;
  always @(negedge clk) begin
    if (!rst) begin
      pend = 0;
      r_valid_extmem = 0;
    end else begin
      r_valid_extmem = 0;
      if (pend) begin
        if (cnt <= 1) begin
          r_valid_extmem = 1;
          data_extmem = mem(paddr);
          pend = 0;
        end else cnt--;
      end
      if (r_request_extmem) begin
        chk("one_outstanding", 64'(pend), 64'd0);
        if (aq.size() == 0) chk("extra_req", 64'(addr_extmem), 64'hDEAD);
        else chk("req_addr", 64'(addr_extmem), 64'(aq.pop_front()));
        pend = 1;
        cnt = delay;
        paddr = addr_extmem;
      end
      if (write) begin
        if (wq.size() == 0) chk("extra_write", 64'({ram_addr, ram_data}), 64'hDEAD);
        else chk("write", 64'({ram_addr, ram_data}), 64'(wq.pop_front()));
      end
      if (e_op) eop_cnt++;
    end
  end

  task automatic push_exp(input logic [2:0] o, input logic [7:0] tx, input logic [7:0] ty,
                          input logic [7:0] xm, input logic [7:0] ym);
    int w, h, cc, e, k;
    logic [31:0] a;
    w = int'(model_info[7:0]); h = int'(model_info[15:8]);
    cc = int'(model_info[26:16]); e = int'(model_info[37:27]);
    k = 0;
    case (o)
      3'd0: begin
        aq.push_back(32'd0); aq.push_back(32'd1);
        model_info = {info1[9:0], info0};
      end
      3'd1, 3'd2: for (int i = 0; i < cc * e; i++) begin
        a = (o == 3'd1 ? 32'h0010_0000 : 32'h0018_0000) + 32'(i);
        aq.push_back(a); wq.push_back({16'(i), mem(a)});
      end
      3'd3: for (int ci = 0; ci < cc; ci++)
        for (int y = int'(ty); y <= int'(ty) + int'(ym); y++)
          for (int x = int'(tx); x <= int'(tx) + int'(xm); x++) begin
            a = 32'h100 + 32'((ci * h + y) * w + x);
            aq.push_back(a); wq.push_back({16'(k), mem(a)});
            k++;
          end
      default: ;
    endcase
  endtask

  task automatic issue(input logic [2:0] o, input logic [7:0] tx, input logic [7:0] ty,
                       input logic [7:0] xm, input logic [7:0] ym);
    push_exp(o, tx, ty, xm, ym);
    @(negedge clk);
    op = o; tx_i = tx; ty_i = ty; x_mem_i = xm; y_mem_i = ym; s_op = 1;
    @(negedge clk);
    s_op = 0;
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [7:0] tx,
                        input logic [7:0] ty, input logic [7:0] xm, input logic [7:0] ym);
    int e0;
    e0 = eop_cnt;
    issue(o, tx, ty, xm, ym);
    for (int i = 0; i < 5000 && eop_cnt == e0; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    chk({tag, "_eop_once"}, 64'(eop_cnt), 64'(e0 + 1));
    chk({tag, "_req_left"}, 64'(aq.size()), 64'd0);
    chk({tag, "_wr_left"}, 64'(wq.size()), 64'd0);
    aq.delete(); wq.delete();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req"}, 64'(r_request_extmem), 64'd0);
    chk({tag, "_addr"}, 64'(addr_extmem), 64'd0);
    chk({tag, "_write"}, 64'(write), 64'd0);
    chk({tag, "_ram"}, 64'({ram_addr, ram_data}), 64'd0);
    chk({tag, "_inf"}, 64'(inf_conv), 64'd0);
    chk({tag, "_eop"}, 64'(e_op), 64'd0);
  endtask

  initial begin
    int e0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1;
    repeat (2) @(negedge clk);

    info0 = 32'h0810_1C1C; info1 = 32'h0000_0001;
    run_op("op0", 3'd0, 0, 0, 0, 0);
    chk("op0_inf", 64'(inf_conv), 64'h1_0810_1C1C);

    run_op("nop5", 3'd5, 0, 0, 0, 0);

    info0 = 32'h0001_1C1C; info1 = 0;   // W=H=28, C=1, E=0
    run_op("op0b", 3'd0, 0, 0, 0, 0);
    chk("op0b_inf", 64'(inf_conv), 64'(model_info));
    run_op("op3_row", 3'd3, 8'd23, 8'd0, 8'd22, 8'd0);
    run_op("op1_e0", 3'd1, 0, 0, 0, 0);

    info0 = 32'h1802_1C1C; info1 = 0;   // W=H=28, C=2, E=3
    run_op("op0c", 3'd0, 0, 0, 0, 0);
    chk("op0c_inf", 64'(inf_conv), 64'(model_info));
    delay = 1; run_op("op1_d1", 3'd1, 0, 0, 0, 0);
    delay = 5; run_op("op1_d5", 3'd1, 0, 0, 0, 0);
    delay = 3; run_op("op2", 3'd2, 0, 0, 0, 0);
    delay = 2; run_op("op3_tile", 3'd3, 8'd3, 8'd2, 8'd1, 8'd1);

    // Abort a long tile fetch with reset.
    e0 = eop_cnt;
    issue(3'd3, 8'd0, 8'd0, 8'd9, 8'd9);
    repeat (30) @(negedge clk);
    rst = 0;
    #1;
    chk_zero("abort");
    aq.delete(); wq.delete();
    model_info = 0;
    repeat (3) @(negedge clk);
    rst = 1;
    repeat (3) @(negedge clk);
    chk("abort_no_eop", 64'(eop_cnt), 64'(e0));

    run_op("op3_c0", 3'd3, 8'd0, 8'd0, 8'd3, 8'd3);
    run_op("op0d", 3'd0, 0, 0, 0, 0);
    chk("op0d_inf", 64'(inf_conv), 64'(model_info));
    delay = 4; run_op("op3_restart", 3'd3, 8'd5, 8'd1, 8'd2, 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
